myniosiicpu_button_pio: RTL

Parametrised, interrupt-capable input PIO for push-buttons and switches on the Nios II system bus. Each of `WIDTH` input channels is synchronised, debounced by a per-channel counter and edge-detected with a selectable edge type. Edges latch into a write-1-to-clear capture register, and a maskable level interrupt is raised to the CPU. It is the successor to the fixed 4-bit, rising-edge, polled key port and sits on the same Avalon-MM slave fabric.

---
 rtl/myniosiicpu_button_pio_if.sv | 32 +++
 rtl/myniosiicpu_button_pio.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/myniosiicpu_button_pio_if.sv
`default_nettype none
// ============================================================================
// Module   : myniosiicpu_button_pio_if
// Brief    : Avalon-MM slave bus bundle for the button/switch input PIO.
// Revision : 1.0 - initial release
// ============================================================================
interface myniosiicpu_button_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  // CPU / fabric side
  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  // PIO side
  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/myniosiicpu_button_pio.sv
`default_nettype none
// ============================================================================
// Module   : myniosiicpu_button_pio
// Brief    : Interrupt-capable input PIO. Each channel is synchronised,
//            debounced, edge-detected; edges latch into a W1C capture
//            register that drives a maskable level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module myniosiicpu_button_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter logic [31:0] RESET_MASK      = 32'h0
) (
  input  wire               clk,
  input  wire               reset_n,
  myniosiicpu_button_pio_if.slave bus,
  input  wire [WIDTH-1:0]   in_port,
  output logic              irq
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       ADDR_DATA = 2'd0;
  localparam logic [1:0]       ADDR_RAW  = 2'd1;
  localparam logic [1:0]       ADDR_MASK = 2'd2;
  localparam logic [1:0]       ADDR_CAP  = 2'd3;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] stable_q, prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      readdata_q, readdata_d;
  wire  [WIDTH-1:0] stable_d;
  wire  [WIDTH-1:0] edge_det;
  logic             wr_en;
  logic [WIDTH-1:0] clr_bits;
  logic             unused_wdata;

  // Upper write-data bits beyond WIDTH carry no meaning for this block.
  assign unused_wdata = ^bus.writedata;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  end

  // Per-channel debounce: a new level is accepted only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stb_d;

    // Next-state for this channel's counter and accepted level.
    always_comb begin
      cnt_d = cnt_q;
      stb_d = stable_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        stb_d = s2_q[i];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Disagreement counter register.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    assign stable_d[i] = stb_d;
  end

  // Debounced level and its one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      prev_q   <= '0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end

  if (EDGE_TYPE == 0) begin : g_rise
    assign edge_det = stable_q & ~prev_q;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign edge_det = ~stable_q & prev_q;
  end else begin : g_any
    assign edge_det = stable_q ^ prev_q;
  end

  // Bus decode, W1C capture (a fresh edge beats a clear) and mask update.
  always_comb begin
    wr_en    = bus.chipselect & ~bus.write_n;
    clr_bits = '0;
    mask_d   = mask_q;
    if (wr_en && (bus.address == ADDR_CAP))  clr_bits = bus.writedata[WIDTH-1:0];
    if (wr_en && (bus.address == ADDR_MASK)) mask_d   = bus.writedata[WIDTH-1:0];
    cap_d = (cap_q & ~clr_bits) | edge_det;
  end

  // Read mux; selected register is zero-extended to the bus width.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA: readdata_d = 32'(stable_q);
      ADDR_RAW:  readdata_d = 32'(s2_q);
      ADDR_MASK: readdata_d = 32'(mask_q);
      default:   readdata_d = 32'(cap_q);
    endcase
  end

  // Control/status registers and the registered read port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= RESET_MASK[WIDTH-1:0];
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(cap_q & mask_q);

endmodule
`default_nettype wire
